// File: rtl/mul_if.sv
// mul_if: request/response bundle between issue logic and the iterative RV32M multiplier.
//
// Handshake: the issuer raises start with funct/op_a/op_b valid. The unit
// samples them only while idle. busy is high from the cycle after acceptance
// until done rises. done is a one-cycle pulse, and result holds until the
// next done.
interface mul_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      funct;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    // Issue side: drives the request and observes status and result.
    modport master (
        output start, funct, op_a, op_b,
        input  busy, done, result
    );

    // Multiplier side.
    modport slave (
        input  start, funct, op_a, op_b,
        output busy, done, result
    );
endinterface

// File: rtl/mul_unit.sv
// mul_unit: iterative RV32M multiplier for MUL, MULH, MULHSU and MULHU.
// The datapath works on operand magnitudes and does one conditional add plus
// one right shift per cycle. A final cycle negates the 2*XLEN product when
// exactly one operand was negative.
//
// Optional feature: define MUL_ZERO_SKIP_EN to bypass the iterations when
// either operand is zero at acceptance (IDLE -> FIX with a zero product).
module mul_unit #(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    mul_if.slave       bus,
    output logic [1:0] dbg_state
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [XLEN-1:0] ONE_X    = XLEN'(1);
    localparam logic [2*XLEN-1:0] ONE_P  = (2*XLEN)'(1);

    localparam logic [1:0] F_MUL    = 2'b00;
    localparam logic [1:0] F_MULH   = 2'b01;
    localparam logic [1:0] F_MULHSU = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        funct_q, funct_d;
    logic              neg_q, neg_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Operand decode, done on the live request inputs while idle.
    logic            sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    // Datapath intermediates.
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     hi_next;
    logic [2*XLEN-1:0] p_fix;

    // Signedness and magnitude of the incoming operands. The most negative
    // value negates to itself, which reads correctly as unsigned 2^(XLEN-1).
    always_comb begin
        sign_a = bus.op_a[XLEN-1] & ((bus.funct == F_MULH) | (bus.funct == F_MULHSU));
        sign_b = bus.op_b[XLEN-1] & (bus.funct == F_MULH);
        mag_a  = sign_a ? (~bus.op_a + ONE_X) : bus.op_a;
        mag_b  = sign_b ? (~bus.op_b + ONE_X) : bus.op_b;
    end

    // Conditional add into the upper product half. The carry becomes the new
    // top bit once the shift is applied. Also computes the sign fix-up value.
    always_comb begin
        add_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q};
        hi_next = mplier_q[0] ? add_sum : {1'b0, prod_q[2*XLEN-1:XLEN]};
        p_fix   = neg_q ? (~prod_q + ONE_P) : prod_q;
    end

    // Next-state and next-register computation for the IDLE/CALC/FIX sequence.
    always_comb begin
        state_d  = state_q;
        funct_d  = funct_q;
        neg_d    = neg_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    funct_d  = bus.funct;
                    neg_d    = sign_a ^ sign_b;
                    mcand_d  = mag_a;
                    mplier_d = mag_b;
                    prod_d   = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
`ifdef MUL_ZERO_SKIP_EN
                    // A zero operand gives a zero product, so go straight to FIX.
                    if ((bus.op_a == '0) || (bus.op_b == '0)) begin
                        state_d = ST_FIX;
                    end else begin
                        state_d = ST_CALC;
                    end
`else
                    state_d  = ST_CALC;
`endif
                end
            end

            ST_CALC: begin
                // {carry, prod, mplier} >> 1. The low product bit moves into
                // the vacated multiplier top bit and is never consumed.
                prod_d   = {hi_next, prod_q[XLEN-1:1]};
                mplier_d = {prod_q[0], mplier_q[XLEN-1:1]};
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end
            end

            ST_FIX: begin
                if (funct_q == F_MUL) begin
                    result_d = p_fix[XLEN-1:0];
                end else begin
                    result_d = p_fix[2*XLEN-1:XLEN];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers. Reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            funct_q  <= '0;
            neg_q    <= 1'b0;
            prod_q   <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            funct_q  <= funct_d;
            neg_q    <= neg_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // Every output comes straight from a flop.
    always_comb begin
        bus.busy   = busy_q;
        bus.done   = done_q;
        bus.result = result_q;
        dbg_state  = state_q;
    end
endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: randomized and directed checks of mul_unit against a
// plain-arithmetic 64-bit product model. Latency expectations follow the
// MUL_ZERO_SKIP_EN setting of the build.
module tb_mul_unit;
  localparam int XLEN = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  mul_if #(.XLEN(XLEN)) bus ();

  mul_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [XLEN-1:0] exp_q[$];
  int              lat_q[$];

  task automatic check_eq(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: full product from sign/zero-extended operands, low or high word.
  function automatic logic [XLEN-1:0] model(input logic [1:0] f, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    longint          sa, sb;
    logic [63:0]     p;
    sa = (f == 2'b01 || f == 2'b10) ? longint'($signed(a)) : longint'({32'b0, a});
    sb = (f == 2'b01) ? longint'($signed(b)) : longint'({32'b0, b});
    p  = 64'(sa * sb);
    return (f == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Edges from acceptance to visible done (equal to the busy-high cycle count).
  function automatic int exp_lat(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
`ifdef MUL_ZERO_SKIP_EN
    return (a == 0 || b == 0) ? 1 : 33;
`else
    if (a == b && a != a) return 0;  // keeps arguments referenced in this build
    return 33;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge while idle; returns at the negedge after acceptance
  // with start still high.
  task automatic launch(input logic [1:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    bus.start = 1'b1;
    bus.funct = f;
    bus.op_a  = a;
    bus.op_b  = b;
    exp_q.push_back(model(f, a, b));
    lat_q.push_back(exp_lat(a, b));
    @(negedge clk);
  endtask

  // Called at the first negedge after acceptance. Waits (bounded) for done and
  // checks result, latency and busy duration. glitch_at > 0 pulses start with
  // unrelated operands during the operation.
  task automatic wait_result(input string tag, input int glitch_at);
    int n = 0;
    int busy_n = 0;
    logic [XLEN-1:0] exp;
    int el;
    while (!bus.done && n < 200) begin
      if (glitch_at > 0 && n == glitch_at) begin
        bus.start = 1'b1;
        bus.funct = 2'($urandom_range(0, 3));
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;
      end else if (glitch_at > 0 && n == glitch_at + 1) begin
        bus.start = 1'b0;
      end
      busy_n += int'(bus.busy);
      @(negedge clk);
      n++;
    end
    exp = exp_q.pop_front();
    el  = lat_q.pop_front();
    check_eq({tag, "_done"}, XLEN'(bus.done), XLEN'(1));
    check_eq({tag, "_result"}, bus.result, exp);
    check_eq({tag, "_latency"}, XLEN'(n), XLEN'(el));
    check_eq({tag, "_busy_cycles"}, XLEN'(busy_n), XLEN'(el));
    check_eq({tag, "_busy_at_done"}, XLEN'(bus.busy), XLEN'(0));
  endtask

  task automatic do_op(input string tag, input logic [1:0] f, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b);
    launch(f, a, b);
    bus.start = 1'b0;
    wait_result(tag, 0);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, XLEN'(bus.done), XLEN'(0));
  endtask

  function automatic logic [XLEN-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [XLEN-1:0] a2, b2;
    int done_cnt;

    bus.start = 1'b0;
    bus.funct = 2'b00;
    bus.op_a  = '0;
    bus.op_b  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check_eq("reset_busy", XLEN'(bus.busy), XLEN'(0));
    check_eq("reset_done", XLEN'(bus.done), XLEN'(0));
    check_eq("reset_result", bus.result, XLEN'(0));
    check_eq("reset_state", XLEN'(dbg_state), XLEN'(0));

    // Directed cases with hand-known answers.
    do_op("mul_7x6", 2'b00, 32'd7, 32'd6);
    check_eq("mul_7x6_const", bus.result, 32'd42);
    do_op("mulh_m1_min", 2'b01, 32'hFFFF_FFFF, 32'h8000_0000);
    check_eq("mulh_m1_min_const", bus.result, 32'h0000_0000);
    do_op("mulhu_m1_min", 2'b11, 32'hFFFF_FFFF, 32'h8000_0000);
    check_eq("mulhu_m1_min_const", bus.result, 32'h7FFF_FFFF);
    do_op("mulhsu_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    check_eq("mulhsu_min_m1_const", bus.result, 32'h8000_0000);
    do_op("mul_min_m1", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    check_eq("mul_min_m1_const", bus.result, 32'h8000_0000);
    do_op("mulh_min_min", 2'b01, 32'h8000_0000, 32'h8000_0000);

    // start during CALC must be ignored.
    launch(2'b01, 32'hDEAD_BEEF, 32'h1234_5679);
    bus.start = 1'b0;
    wait_result("glitch", 5);
    @(negedge clk);
    check_eq("glitch_done_pulse", XLEN'(bus.done), XLEN'(0));

    // start held high across done: second op accepted in the done cycle.
    a2 = 32'hCAFE_0001;
    b2 = 32'hFFFF_FF03;
    launch(2'b10, 32'h8765_4321, 32'h0000_0101);
    bus.funct = 2'b01;
    bus.op_a  = a2;
    bus.op_b  = b2;
    exp_q.push_back(model(2'b01, a2, b2));
    lat_q.push_back(exp_lat(a2, b2));
    wait_result("b2b_first", 0);
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("b2b_done_drop", XLEN'(bus.done), XLEN'(0));
    check_eq("b2b_second_busy", XLEN'(bus.busy), XLEN'(1));
    wait_result("b2b_second", 0);
    @(negedge clk);

    // Zero operand: skip path when enabled, full latency otherwise.
    do_op("mulhu_zero", 2'b11, 32'h0000_0000, 32'h1234_5678);
    do_op("mul_zero_b", 2'b00, 32'h1357_9BDF, 32'h0000_0000);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      do_op($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), pick_operand(), pick_operand());
    end

    // Asynchronous reset mid-CALC.
    do_op("pre_rst", 2'b00, 32'd7, 32'd6);
    launch(2'b11, 32'hFFFF_0000, 32'h0F0F_0F0F);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_busy", XLEN'(bus.busy), XLEN'(0));
    check_eq("rst_done", XLEN'(bus.done), XLEN'(0));
    check_eq("rst_result", bus.result, XLEN'(0));
    void'(exp_q.pop_front());
    void'(lat_q.pop_front());
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      done_cnt += int'(bus.done);
    end
    check_eq("rst_no_done", XLEN'(done_cnt), XLEN'(0));
    check_eq("rst_state_idle", XLEN'(dbg_state), XLEN'(0));

    do_op("post_rst", 2'b01, 32'hFFFF_FFF9, 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mul_unit.md
# mul_unit

Iterative RV32M multiplier executing MUL, MULH, MULHSU and MULHU with a start/busy/done handshake. It sits in the execute stage beside the combinational ALU. It consumes the same rs1/rs2 operands and funct3 low bits from the decode/issue logic. Its registered result feeds the writeback mux while the pipeline is stalled on `busy`. It uses a single 64-bit accumulate-and-shift datapath: one conditional add per cycle, one final sign fix-up.

## Interface
- `XLEN`, 32, operand and result width; the product register is 2*XLEN.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `funct`  in  2  00 MUL (low word), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high).
- `op_a`  in  XLEN  rs1 value; sampled with `start`.
- `op_b`  in  XLEN  rs2 value; sampled with `start`.
- `busy`  out  1  high from the cycle after acceptance until the cycle `done` rises.
- `done`  out  1  single-cycle pulse; `result` is valid from this cycle on.
- `result`  out  XLEN  registered result; holds until the next `done`.

## Operation
- States: IDLE, CALC, FIX.
- IDLE with `start`=1:
  - Latch `funct`.
  - Compute `sign_a` = op_a[XLEN-1] & (funct is MULH or MULHSU).
  - Compute `sign_b` = op_b[XLEN-1] & (funct is MULH).
  - Load `mcand` = |op_a|, `mplier` = |op_b|. Magnitude uses two's-complement negate when the sign is set; the most negative value is taken as unsigned 2^(XLEN-1).
  - Set `neg` = sign_a ^ sign_b, `prod` = 0, `cnt` = 0.
  - Go to CALC; `busy` goes to 1.
- CALC, each cycle:
  - If mplier[0], prod_hi += mcand. The carry-out is kept as bit 2*XLEN and shifted in.
  - Then shift {carry, prod, mplier} right by 1 and increment `cnt`.
  - After the XLEN-th iteration (`cnt` = XLEN-1 at the edge), go to FIX.
- FIX, one cycle:
  - If `neg`, p = ~prod + 1 (64-bit); otherwise p = prod.
  - `result` = p[XLEN-1:0] for MUL, else p[2*XLEN-1:XLEN].
  - `done` = 1, `busy` = 0, go to IDLE.
- `start` while busy (CALC/FIX) is ignored. Operands are not re-sampled.
- `start` in the cycle `done` is high is accepted, since the state is already IDLE. Back-to-back operations are legal.
- MUL low word is identical for all signedness choices, so MUL uses the unsigned path.
- Reset: state IDLE, `busy`=0, `done`=0, `result`=0, `prod`/`mplier`/`mcand`/`cnt`/`neg`=0.
- Reset asserted mid-operation aborts it. No `done` is produced, and `result` clears to 0.

## Timing
- Acceptance edge = E0. The CALC iterations occupy edges E1..E32 (XLEN=32). FIX completes at E33.
- `done`=1 and the new `result` are visible in the cycle after E33: latency 33 cycles start-to-done, 34 including the acceptance cycle.
- `busy` is 1 for the cycles following E0..E32, i.e. exactly 33 cycles.
- `done` is high for exactly one cycle and is deasserted at the next edge regardless of `start`.
- No combinational path from inputs to outputs.

## Configuration
- `MUL_ZERO_SKIP_EN` defined:
  - If op_a==0 or op_b==0 at acceptance, the state goes IDLE→FIX directly with `prod`=0.
  - `done` is visible after 2 edges (E0, E1); `busy` is high for 1 cycle.
- Undefined: every operation takes the full XLEN CALC cycles, giving fixed latency.

## Test plan
- MUL, op_a=7, op_b=6 → `result`=42, `done` pulses once, 33 cycles after the acceptance edge; `busy` high 33 cycles.
- MULH, op_a=0xFFFFFFFF (−1), op_b=0x80000000 → `result`=0x00000000 (product 2^31). Also MULHU on the same operands → 0x7FFFFFFF.
- MULHSU, op_a=0x80000000, op_b=0xFFFFFFFF → `result`=0x80000000. MUL on the same operands → 0x80000000.
- `start` pulsed during CALC with different operands → ignored; first result unchanged. `start` held high across `done` → second operation accepted in the same cycle `done` is high.
- `rst` asserted at cycle 10 of CALC → `busy`, `done`, `result` are 0 immediately (asynchronously). No `done` after release.
- With `MUL_ZERO_SKIP_EN`, MULHU op_a=0, op_b=0x12345678 → `result`=0, `done` 2 edges after acceptance. Without the macro → `result`=0 at 33 cycles.
